// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - frames RX FIFO bytes into ALU operands and pushes the ALU result to the TX FIFO
module uart_alu_interface #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_fiforx_empty,
   input  logic [NB_DATA-1:0] i_fiforx_data,
   output logic               o_fiforx_read,
   input  logic               i_fifotx_full,
   output logic               o_fifotx_write,
   output logic [NB_DATA-1:0] o_fifotx_data,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic               o_busy
);

   localparam logic [2:0] S_A    = 3'd0;
   localparam logic [2:0] S_B    = 3'd1;
   localparam logic [2:0] S_OP   = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_SEND = 3'd4;

   logic [2:0]         state;
   logic [2:0]         state_next;
   logic [NB_DATA-1:0] a_reg;
   logic [NB_DATA-1:0] b_reg;
   logic [NB_OP-1:0]   op_reg;
   logic [NB_DATA-1:0] result_reg;
   logic               rx_phase;
   logic               rx_pop;
   logic               tx_push;

   // Handshake strobes depend only on state and the FIFO flags, so a pop or
   // push can never be issued against an empty or full FIFO.
   always_comb begin
      rx_phase = (state == S_A) || (state == S_B) || (state == S_OP);
      rx_pop   = rx_phase && !i_fiforx_empty;
      tx_push  = (state == S_SEND) && !i_fifotx_full;
   end

   // Next-state logic: each receive state advances only on a pop, EXEC always
   // advances, SEND waits for TX room.
   always_comb begin
      state_next = state;
      case (state)
         S_A:     if (rx_pop)  state_next = S_B;
         S_B:     if (rx_pop)  state_next = S_OP;
         S_OP:    if (rx_pop)  state_next = S_EXEC;
         S_EXEC:               state_next = S_SEND;
         S_SEND:  if (tx_push) state_next = S_A;
         default:              state_next = S_A;
      endcase
   end

   // State register; reset abandons any partially collected frame.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= S_A;
      end else begin
         state <= state_next;
      end
   end

   // Operand/opcode capture on the pop cycle of the matching state; the
   // opcode byte keeps only its low NB_OP bits.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         a_reg  <= '0;
         b_reg  <= '0;
         op_reg <= '0;
      end else if (rx_pop) begin
         case (state)
            S_A:     a_reg  <= i_fiforx_data;
            S_B:     b_reg  <= i_fiforx_data;
            S_OP:    op_reg <= i_fiforx_data[NB_OP-1:0];
            default: ;
         endcase
      end
   end

   // Result capture after the ALU has had the EXEC cycle to settle; held
   // through SEND so the pushed byte stays stable across TX stalls.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         result_reg <= '0;
      end else if (state == S_EXEC) begin
         result_reg <= i_alu_result;
      end
   end

   // Output wiring: registers drive the ALU and TX data directly.
   always_comb begin
      o_fiforx_read  = rx_pop;
      o_fifotx_write = tx_push;
      o_fifotx_data  = result_reg;
      o_alu_a        = a_reg;
      o_alu_b        = b_reg;
      o_alu_op       = op_reg;
      o_busy         = (state != S_A);
   end

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - table-driven scoreboard bench for uart_alu_interface
module tb_uart_alu_interface;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_empty = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_read;
   logic       tx_full = 1'b0;
   logic       tx_write;
   logic [7:0] tx_data;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic [7:0] alu_result;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int rd_count = 0;
   int wr_count = 0;
   int last_rd_cycle = 0;
   int last_wr_cycle = 0;

   logic [7:0] rx_q[$];
   logic [7:0] sb[$];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op_byte;
      logic [7:0] result;
   } vec_t;

   vec_t vecs[6];

   uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_fiforx_empty (rx_empty),
      .i_fiforx_data  (rx_data),
      .o_fiforx_read  (rx_read),
      .i_fifotx_full  (tx_full),
      .o_fifotx_write (tx_write),
      .o_fifotx_data  (tx_data),
      .o_alu_a        (alu_a),
      .o_alu_b        (alu_b),
      .o_alu_op       (alu_op),
      .i_alu_result   (alu_result),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;

   // Reference ALU attached to the registered operands
   always_comb begin
      case (alu_op)
         6'h20:   alu_result = alu_a + alu_b;
         6'h22:   alu_result = alu_a - alu_b;
         6'h24:   alu_result = alu_a & alu_b;
         default: alu_result = 8'h00;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void rx_refresh();
      rx_empty = (rx_q.size() == 0);
      rx_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
   endfunction

   task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] res);
      rx_q.push_back(a);
      rx_q.push_back(b);
      rx_q.push_back(op);
      sb.push_back(res);
      rx_refresh();
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_idle(input string name, input int limit);
      int k;
      for (k = 0; k < limit; k++) begin
         tick(1);
         if (sb.size() == 0 && !busy) break;
      end
      if (k == limit) check({name, "_timeout"}, 1, 0);
   endtask

   // FIFO models: strobes sampled mid-cycle, pops applied just after the edge
   initial begin
      forever begin
         logic rd;
         logic wr;
         logic [7:0] wd;
         @(negedge clk);
         cycle++;
         rd = rx_read;
         wr = tx_write;
         wd = tx_data;
         if (rd) begin
            check("read_while_empty", rx_empty, 0);
            rd_count++;
            last_rd_cycle = cycle;
         end
         if (wr) begin
            check("write_while_full", tx_full, 0);
            wr_count++;
            last_wr_cycle = cycle;
            if (sb.size() == 0) begin
               check("unexpected_write", wd, 8'hxx);
            end else begin
               check("tx_data", wd, sb.pop_front());
            end
         end
         @(posedge clk);
         #1;
         if (rd && rx_q.size() != 0) begin
            void'(rx_q.pop_front());
            rx_refresh();
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd0;
      int wr0;
      vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
      vecs[1] = '{8'hF0, 8'h0F, 8'hE4, 8'h00};
      vecs[2] = '{8'h10, 8'h20, 8'h22, 8'hF0};
      vecs[3] = '{8'hFF, 8'h01, 8'h20, 8'h00};
      vecs[4] = '{8'h00, 8'h01, 8'h22, 8'hFF};
      vecs[5] = '{8'hAA, 8'h5F, 8'h24, 8'h0A};

      // Reset and idle with RX empty
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      check("reset_alu_a", alu_a, 0);
      check("reset_alu_b", alu_b, 0);
      check("reset_alu_op", alu_op, 0);
      check("reset_tx_data", tx_data, 0);
      check("reset_busy", busy, 0);
      tick(20);
      check("idle_reads", rd_count, 0);
      check("idle_writes", wr_count, 0);
      check("idle_busy", busy, 0);

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         rd0 = rd_count;
         wr0 = wr_count;
         push_frame(vecs[i].a, vecs[i].b, vecs[i].op_byte, vecs[i].result);
         wait_idle($sformatf("vec%0d", i), 50);
         tick(3);
         check($sformatf("vec%0d_reads", i), rd_count - rd0, 3);
         check($sformatf("vec%0d_writes", i), wr_count - wr0, 1);
         check($sformatf("vec%0d_latency", i), last_wr_cycle - last_rd_cycle, 2);
         check($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].a);
         check($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].b);
         check($sformatf("vec%0d_alu_op", i), alu_op, {2'b00, vecs[i].op_byte[5:0]});
      end

      // A arrives, then RX stays empty for 50 cycles before B and OP
      rd0 = rd_count;
      wr0 = wr_count;
      rx_q.push_back(8'h30);
      rx_refresh();
      tick(50);
      check("stall_rx_reads", rd_count - rd0, 1);
      check("stall_rx_busy", busy, 1);
      check("stall_rx_alu_a", alu_a, 8'h30);
      check("stall_rx_writes", wr_count - wr0, 0);
      rx_q.push_back(8'h0C);
      rx_q.push_back(8'h22);
      sb.push_back(8'h24);
      rx_refresh();
      wait_idle("stall_rx", 50);
      tick(3);
      check("stall_rx_total_writes", wr_count - wr0, 1);

      // TX full during SEND with two more frames queued
      rd0 = rd_count;
      wr0 = wr_count;
      tx_full = 1'b1;
      push_frame(vecs[0].a, vecs[0].b, vecs[0].op_byte, vecs[0].result);
      tick(8);
      push_frame(vecs[1].a, vecs[1].b, vecs[1].op_byte, vecs[1].result);
      push_frame(vecs[2].a, vecs[2].b, vecs[2].op_byte, vecs[2].result);
      tick(30);
      check("full_writes", wr_count - wr0, 0);
      check("full_reads", rd_count - rd0, 3);
      check("full_busy", busy, 1);
      check("full_hold_data", tx_data, vecs[0].result);
      tx_full = 1'b0;
      wait_idle("full", 100);
      tick(3);
      check("full_release_writes", wr_count - wr0, 3);
      check("full_release_reads", rd_count - rd0, 9);

      // Reset mid-frame after A and B have been popped
      rd0 = rd_count;
      rx_q.push_back(8'h11);
      rx_q.push_back(8'h22);
      rx_refresh();
      tick(4);
      check("midreset_reads", rd_count - rd0, 2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midreset_alu_a", alu_a, 0);
      check("midreset_alu_b", alu_b, 0);
      check("midreset_alu_op", alu_op, 0);
      check("midreset_busy", busy, 0);
      check("midreset_tx_data", tx_data, 0);
      wr0 = wr_count;
      push_frame(8'h07, 8'h02, 8'h22, 8'h05);
      wait_idle("midreset", 50);
      tick(3);
      check("midreset_writes", wr_count - wr0, 1);
      check("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
